// File: rtl/sp_weight_compressor.sv
`default_nettype none
// ============================================================================
// Module      : sp_weight_compressor
// Description : Streaming 2:4 structured-sparsity weight encoder. Each dense
//               beat of eight signed 8-bit weights is reduced to four
//               retained weights plus four 2-bit in-half positions. Halves
//               with more than two nonzeros are flagged and counted.
//               Two-stage pipeline (S1 = dense input, S2 = compressed).
// Options     : SPW_MAG_PRUNE_EN - when defined, over-full halves keep the
//               two largest-magnitude weights; otherwise the two lowest
//               nonzero positions.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_weight_compressor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_dense,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_weight,
  output logic [7:0]       out_idx,
  output logic             out_last,
  output logic             out_viol,
  output logic             done,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Compress one half: returns {viol, p_b, p_a, w[p_b], w[p_a]} with p_a < p_b.
  function automatic logic [20:0] compress_half(input logic [31:0] h);
    logic [3:0][7:0] wv;
    logic [3:0]      nz;
    logic [3:0]      sel;
    logic [2:0]      cnt;
    logic [1:0]      pa;
    logic [1:0]      pb;
    int              n;
`ifdef SPW_MAG_PRUNE_EN
    logic [3:0][8:0] mag;
    int              rank;
`endif
    wv  = h;
    cnt = '0;
    for (int i = 0; i < 4; i++) begin
      nz[i] = (wv[i] != 8'd0);
      cnt   = cnt + {2'b00, nz[i]};
    end
    // Two lowest nonzero positions first, then lowest remaining positions
    // as zero-weight fillers when the half has fewer than two nonzeros.
    sel = '0;
    n   = 0;
    for (int i = 0; i < 4; i++) begin
      if (nz[i] && n < 2) begin
        sel[i] = 1'b1;
        n      = n + 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!sel[i] && n < 2) begin
        sel[i] = 1'b1;
        n      = n + 1;
      end
    end
`ifdef SPW_MAG_PRUNE_EN
    // Over-full half: keep the two largest |w|, lower position wins a tie.
    if (cnt >= 3'd3) begin
      for (int i = 0; i < 4; i++) begin
        mag[i] = wv[i][7] ? (9'd0 - {1'b1, wv[i]}) : {1'b0, wv[i]};
      end
      for (int i = 0; i < 4; i++) begin
        rank = 0;
        for (int j = 0; j < 4; j++) begin
          if ((mag[j] > mag[i]) || ((mag[j] == mag[i]) && (j < i))) begin
            rank = rank + 1;
          end
        end
        sel[i] = (rank < 2);
      end
    end
`endif
    pa = '0;
    pb = '0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) pa = i[1:0];
    end
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) pb = i[1:0];
    end
    return {(cnt >= 3'd3), pb, pa, wv[pb], wv[pa]};
  endfunction

  logic             s1_valid_q;
  logic [63:0]      s1_dense_q;
  logic             s1_last_q;
  logic             s2_valid_q;
  logic [31:0]      s2_weight_q;
  logic [7:0]       s2_idx_q;
  logic             s2_last_q;
  logic             s2_viol_q;
  logic             done_q;
  logic             done_d;
  logic [CNT_W-1:0] blk_cnt_q;
  logic [CNT_W-1:0] blk_cnt_d;
  logic [CNT_W-1:0] viol_cnt_q;
  logic [CNT_W-1:0] viol_cnt_d;
  logic [20:0]      comp_lo;
  logic [20:0]      comp_hi;
  logic             s2_load;
  logic             s1_load;
  logic             out_hs;

  // Stage-advance handshakes.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = s2_valid_q && out_ready;

  // Compressor on the S1 dense word.
  always_comb begin
    comp_lo = compress_half(s1_dense_q[31:0]);
    comp_hi = compress_half(s1_dense_q[63:32]);
  end

  // Stage 1: capture the dense beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_dense_q <= '0;
      s1_last_q  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_dense_q <= in_dense;
        s1_last_q  <= in_last;
      end
    end
  end

  // Stage 2: capture the compressed beat; holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q  <= 1'b0;
      s2_weight_q <= '0;
      s2_idx_q    <= '0;
      s2_last_q   <= 1'b0;
      s2_viol_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_weight_q <= {comp_hi[15:0], comp_lo[15:0]};
        s2_idx_q    <= {comp_hi[19:16], comp_lo[19:16]};
        s2_last_q   <= s1_last_q;
        s2_viol_q   <= comp_hi[20] | comp_lo[20];
      end
    end
  end

  // Counter and done next-state; clear overrides a same-cycle increment.
  always_comb begin
    blk_cnt_d  = blk_cnt_q;
    viol_cnt_d = viol_cnt_q;
    done_d     = out_hs && s2_last_q;
    if (cnt_clr) begin
      blk_cnt_d  = '0;
      viol_cnt_d = '0;
    end else if (out_hs) begin
      blk_cnt_d = blk_cnt_q + C_CNT_ONE;
      if (s2_viol_q && (viol_cnt_q != {CNT_W{1'b1}})) begin
        viol_cnt_d = viol_cnt_q + C_CNT_ONE;
      end
    end
  end

  // Counter and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_q  <= '0;
      viol_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      blk_cnt_q  <= blk_cnt_d;
      viol_cnt_q <= viol_cnt_d;
      done_q     <= done_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_weight = s2_weight_q;
  assign out_idx    = s2_idx_q;
  assign out_last   = s2_last_q;
  assign out_viol   = s2_viol_q;
  assign done       = done_q;
  assign blk_cnt    = blk_cnt_q;
  assign viol_cnt   = viol_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_weight_compressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_weight_compressor
// Description : Directed self-checking bench for sp_weight_compressor.
//               Expected values for over-full halves follow SPW_MAG_PRUNE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_weight_compressor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_dense;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_weight;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        out_viol;
  logic        done;
  logic        cnt_clr;
  logic [15:0] blk_cnt;
  logic [15:0] viol_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sp_weight_compressor #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dense   (in_dense),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_weight (out_weight),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_viol   (out_viol),
    .done       (done),
    .cnt_clr    (cnt_clr),
    .blk_cnt    (blk_cnt),
    .viol_cnt   (viol_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [63:0] bp_beat(input int k);
    return pk(k + 1, 0, 0, 0, 0, -(k + 1), 0, 0);
  endfunction

  function automatic logic [31:0] bp_w(input int k);
    return {8'(-(k + 1)), 8'h00, 8'h00, 8'(k + 1)};
  endfunction

  // One beat through an idle pipeline with out_ready high.
  task automatic run1(input string tag, input logic [63:0] d, input logic last,
                      input logic clr, input logic [31:0] ew, input logic [7:0] ei,
                      input logic ev);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_dense  = d;
    in_last   = last;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk({tag, "_lat_valid0"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_weight"}, out_weight, ew);
    chk({tag, "_idx"}, out_idx, ei);
    chk({tag, "_viol"}, out_viol, ev);
    chk({tag, "_last"}, out_last, last);
    chk({tag, "_done_pre"}, done, 1'b0);
    cnt_clr = clr;
    tick();
    cnt_clr = 1'b0;
    chk({tag, "_done"}, done, last);
  endtask

  initial begin
    logic [31:0] d_w;
    logic [7:0]  d_i;
    logic [31:0] f_w;
    logic [7:0]  f_i;
    int          sent;
    int          rcvd;

`ifdef SPW_MAG_PRUNE_EN
    d_w = 32'h00040380; d_i = 8'h49;
    f_w = 32'h06FB0000; f_i = 8'hC4;
`else
    d_w = 32'h00048001; d_i = 8'h44;
    f_w = 32'h05FB0000; f_i = 8'h44;
`endif

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_dense  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset state.
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_weight", out_weight, 32'h0);
    chk("rst_out_idx", out_idx, 8'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_viol", out_viol, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_blk_cnt", blk_cnt, 16'h0);
    chk("rst_viol_cnt", viol_cnt, 16'h0);
    #10;
    rst = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid_post", out_valid, 1'b0);

    // Tile of four beats; last one carries in_last.
    run1("patA", pk(0, 5, 0, -3, 7, 0, 0, 1), 1'b0, 1'b0, 32'h0107FD05, 8'hCD, 1'b0);
    chk("patA_blk", blk_cnt, 16'd1);
    run1("zero", 64'h0, 1'b0, 1'b0, 32'h00000000, 8'h44, 1'b0);
    run1("single", pk(0, 0, 9, 0, 0, 0, 0, -1), 1'b0, 1'b0, 32'hFF000900, 8'hC8, 1'b0);
    run1("over4", pk(1, -128, 3, 2, 4, 0, 0, 0), 1'b1, 1'b0, d_w, d_i, 1'b1);
    chk("over4_viol_cnt", viol_cnt, 16'd1);
    tick();
    chk("done_one_cycle", done, 1'b0);
    run1("tie", pk(0, 0, 0, 0, -5, 5, -5, 6), 1'b0, 1'b0, f_w, f_i, 1'b1);
    chk("tile_blk", blk_cnt, 16'd5);
    chk("tile_viol_cnt", viol_cnt, 16'd2);

    // Clear concurrent with a violating handshake.
    run1("clr", pk(1, -128, 3, 2, 4, 0, 0, 0), 1'b0, 1'b1, d_w, d_i, 1'b1);
    chk("clr_blk", blk_cnt, 16'd0);
    chk("clr_viol_cnt", viol_cnt, 16'd0);

    // Ten beats back to back with toggling then held-low out_ready.
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 80 && rcvd < 10; c++) begin
      out_ready = (c < 11) ? (c % 2 == 0) : (c >= 16);
      in_valid  = (sent < 10);
      in_dense  = bp_beat(sent);
      in_last   = 1'b0;
      #1;
      if (c == 3)  chk("bp_two_buffered_in_ready", in_ready, 1'b0);
      if (c == 15) chk("bp_stall_in_ready", in_ready, 1'b0);
      if (c == 15) chk("bp_stall_valid", out_valid, 1'b1);
      if (c == 16) chk("bp_release_in_ready", in_ready, 1'b1);
      if (out_valid) begin
        chk("bp_weight", out_weight, bp_w(rcvd));
        chk("bp_idx", out_idx, 8'h44);
      end
      if (out_valid && out_ready) rcvd++;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_received", rcvd, 10);
    chk("bp_blk", blk_cnt, 16'd10);
    chk("bp_viol_cnt", viol_cnt, 16'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_dense  = pk(0, 5, 0, -3, 7, 0, 0, 1);
    in_last   = 1'b1;
    tick();
    in_dense  = pk(0, 0, 9, 0, 0, 0, 0, -1);
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("mid_pre_valid", out_valid, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_weight", out_weight, 32'h0);
    chk("mid_rst_blk", blk_cnt, 16'd0);
    chk("mid_rst_last", out_last, 1'b0);
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_no_stale", out_valid, 1'b0);
      chk("post_rst_no_done", done, 1'b0);
    end
    run1("after_rst", pk(0, 5, 0, -3, 7, 0, 0, 1), 1'b0, 1'b0, 32'h0107FD05, 8'hCD, 1'b0);
    chk("after_rst_blk", blk_cnt, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
